// File: rtl/mem_rd_arbiter.sv
// Two-master (IFU/LSU) read arbiter sharing one memory AR/R channel.
// One outstanding read at a time, ID-tagged responses, per-read timeout.
module mem_rd_arbiter #(
   parameter bit          LSU_PRIO = 1'b1,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   input  logic [31:0] ifu_araddr,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   input  logic [31:0] lsu_araddr,
   input  logic [2:0]  lsu_arsize,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_rresp,
   input  logic        lsu_wr_pending,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   output logic [31:0] mem_araddr,
   output logic [2:0]  mem_arsize,
   output logic [3:0]  mem_arid,
   input  logic        mem_rvalid,
   output logic        mem_rready,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_rresp,
   input  logic [3:0]  mem_rid
);

   localparam int unsigned CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [2:0]  IFU_SIZE    = 3'b010;
   localparam logic [3:0]  IFU_ID      = 4'd0;
   localparam logic [3:0]  LSU_ID      = 4'd1;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, RESP, RET} state_t;

   state_t           state;
   logic             last_lsu;
   logic             sel_lsu;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;
   logic [1:0]       rresp_q;

   logic grant_en_c;
   logic grant_lsu_c;
   logic grant_ifu_c;
   logic rsp_hit_c;
   logic tmo_c;
   logic ret_ack_c;

   // Arbitration: LSU wins a tie under fixed priority or when IFU was granted last
   assign grant_en_c  = reset && (state == IDLE) && !lsu_wr_pending;
   assign grant_lsu_c = grant_en_c && lsu_arvalid && (!ifu_arvalid || LSU_PRIO || !last_lsu);
   assign grant_ifu_c = grant_en_c && ifu_arvalid && !grant_lsu_c;
   assign ifu_arready = grant_ifu_c;
   assign lsu_arready = grant_lsu_c;

   assign rsp_hit_c = mem_rvalid && (mem_rid == mem_arid);
   assign tmo_c     = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
   assign ret_ack_c = sel_lsu ? lsu_rready : ifu_rready;

   // Both masters see the shared capture register; only the granted one gets rvalid
   assign ifu_rdata = rdata_q;
   assign ifu_rresp = rresp_q;
   assign lsu_rdata = rdata_q;
   assign lsu_rresp = rresp_q;

   // Transaction sequencer with registered channel outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_lsu    <= 1'b0;
         sel_lsu     <= 1'b0;
         cnt         <= '0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         mem_arvalid <= 1'b0;
         mem_rready  <= 1'b0;
         mem_araddr  <= '0;
         mem_arsize  <= '0;
         mem_arid    <= '0;
         ifu_rvalid  <= 1'b0;
         lsu_rvalid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ifu_c || grant_lsu_c) begin
                  sel_lsu     <= grant_lsu_c;
                  last_lsu    <= grant_lsu_c;
                  mem_araddr  <= grant_lsu_c ? lsu_araddr : ifu_araddr;
                  mem_arsize  <= grant_lsu_c ? lsu_arsize : IFU_SIZE;
                  mem_arid    <= grant_lsu_c ? LSU_ID : IFU_ID;
                  mem_arvalid <= 1'b1;
                  mem_rready  <= 1'b0;
                  state       <= ADDR;
               end else begin
                  // stale beats are sunk while idle
                  mem_rready  <= 1'b1;
               end
            end
            ADDR: begin
               if (mem_arready) begin
                  mem_arvalid <= 1'b0;
                  mem_rready  <= 1'b1;
                  cnt         <= '0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_hit_c || tmo_c) begin
                  rdata_q    <= rsp_hit_c ? mem_rdata : 32'd0;
                  rresp_q    <= rsp_hit_c ? mem_rresp : RESP_SLVERR;
                  mem_rready <= 1'b0;
                  ifu_rvalid <= !sel_lsu;
                  lsu_rvalid <= sel_lsu;
                  state      <= RET;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RET: begin
               if (ret_ack_c) begin
                  ifu_rvalid <= 1'b0;
                  lsu_rvalid <= 1'b0;
                  mem_rready <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: a fixed-priority and a round-robin instance,
// each driven by tables, directed sequences and randomized transactions.
module tb_mem_rd_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk;
   logic        rst_n;
   logic        ifu_arvalid[2], ifu_arready[2], ifu_rvalid[2], ifu_rready[2];
   logic [31:0] ifu_araddr[2], ifu_rdata[2];
   logic [1:0]  ifu_rresp[2];
   logic        lsu_arvalid[2], lsu_arready[2], lsu_rvalid[2], lsu_rready[2], lsu_wr_pending[2];
   logic [31:0] lsu_araddr[2], lsu_rdata[2];
   logic [2:0]  lsu_arsize[2];
   logic [1:0]  lsu_rresp[2];
   logic        mem_arvalid[2], mem_arready[2], mem_rvalid[2], mem_rready[2];
   logic [31:0] mem_araddr[2], mem_rdata[2];
   logic [2:0]  mem_arsize[2];
   logic [3:0]  mem_arid[2], mem_rid[2];
   logic [1:0]  mem_rresp[2];

   int vectors;
   int fails;
   int d;
   bit last_lsu;
   bit prio[2];

   typedef struct {
      bit ifu;
      bit lsu;
      bit wr;
      bit exp_ifu_rdy;
      bit exp_lsu_rdy;
   } vec_t;

   mem_rd_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT(TMO)) u_prio (
      .clock(clk), .reset(rst_n),
      .ifu_arvalid(ifu_arvalid[0]), .ifu_arready(ifu_arready[0]), .ifu_araddr(ifu_araddr[0]),
      .ifu_rvalid(ifu_rvalid[0]), .ifu_rready(ifu_rready[0]), .ifu_rdata(ifu_rdata[0]),
      .ifu_rresp(ifu_rresp[0]),
      .lsu_arvalid(lsu_arvalid[0]), .lsu_arready(lsu_arready[0]), .lsu_araddr(lsu_araddr[0]),
      .lsu_arsize(lsu_arsize[0]), .lsu_rvalid(lsu_rvalid[0]), .lsu_rready(lsu_rready[0]),
      .lsu_rdata(lsu_rdata[0]), .lsu_rresp(lsu_rresp[0]), .lsu_wr_pending(lsu_wr_pending[0]),
      .mem_arvalid(mem_arvalid[0]), .mem_arready(mem_arready[0]), .mem_araddr(mem_araddr[0]),
      .mem_arsize(mem_arsize[0]), .mem_arid(mem_arid[0]), .mem_rvalid(mem_rvalid[0]),
      .mem_rready(mem_rready[0]), .mem_rdata(mem_rdata[0]), .mem_rresp(mem_rresp[0]),
      .mem_rid(mem_rid[0])
   );

   mem_rd_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT(TMO)) u_rr (
      .clock(clk), .reset(rst_n),
      .ifu_arvalid(ifu_arvalid[1]), .ifu_arready(ifu_arready[1]), .ifu_araddr(ifu_araddr[1]),
      .ifu_rvalid(ifu_rvalid[1]), .ifu_rready(ifu_rready[1]), .ifu_rdata(ifu_rdata[1]),
      .ifu_rresp(ifu_rresp[1]),
      .lsu_arvalid(lsu_arvalid[1]), .lsu_arready(lsu_arready[1]), .lsu_araddr(lsu_araddr[1]),
      .lsu_arsize(lsu_arsize[1]), .lsu_rvalid(lsu_rvalid[1]), .lsu_rready(lsu_rready[1]),
      .lsu_rdata(lsu_rdata[1]), .lsu_rresp(lsu_rresp[1]), .lsu_wr_pending(lsu_wr_pending[1]),
      .mem_arvalid(mem_arvalid[1]), .mem_arready(mem_arready[1]), .mem_araddr(mem_araddr[1]),
      .mem_arsize(mem_arsize[1]), .mem_arid(mem_arid[1]), .mem_rvalid(mem_rvalid[1]),
      .mem_rready(mem_rready[1]), .mem_rdata(mem_rdata[1]), .mem_rresp(mem_rresp[1]),
      .mem_rid(mem_rid[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d t=%0t: got %b, expected %b", nm, d, $time, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d t=%0t: got %h, expected %h", nm, d, $time, act, exp);
      end
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         ifu_arvalid[k] = 1'b0; ifu_araddr[k] = '0; ifu_rready[k] = 1'b0;
         lsu_arvalid[k] = 1'b0; lsu_araddr[k] = '0; lsu_arsize[k] = '0;
         lsu_rready[k] = 1'b0;  lsu_wr_pending[k] = 1'b0;
         mem_arready[k] = 1'b0; mem_rvalid[k] = 1'b0; mem_rdata[k] = '0;
         mem_rresp[k] = '0;     mem_rid[k] = '0;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk1({nm, "_ifu_arready"}, ifu_arready[d], 1'b0);
      chk1({nm, "_lsu_arready"}, lsu_arready[d], 1'b0);
      chk1({nm, "_ifu_rvalid"}, ifu_rvalid[d], 1'b0);
      chk1({nm, "_lsu_rvalid"}, lsu_rvalid[d], 1'b0);
      chk1({nm, "_mem_arvalid"}, mem_arvalid[d], 1'b0);
      chk1({nm, "_mem_rready"}, mem_rready[d], 1'b0);
      chk32({nm, "_mem_araddr"}, mem_araddr[d], 32'd0);
      chk32({nm, "_mem_arsize"}, 32'(mem_arsize[d]), 32'd0);
      chk32({nm, "_mem_arid"}, 32'(mem_arid[d]), 32'd0);
      chk32({nm, "_ifu_rdata"}, ifu_rdata[d], 32'd0);
      chk32({nm, "_ifu_rresp"}, 32'(ifu_rresp[d]), 32'd0);
      chk32({nm, "_lsu_rdata"}, lsu_rdata[d], 32'd0);
      chk32({nm, "_lsu_rresp"}, 32'(lsu_rresp[d]), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      last_lsu = 1'b0;
   endtask

   // Raise requests; a request already pending keeps its address
   task automatic req(input bit i, input bit l);
      if (i && !ifu_arvalid[d]) begin
         ifu_arvalid[d] = 1'b1;
         ifu_araddr[d]  = $urandom;
      end
      if (!i) ifu_arvalid[d] = 1'b0;
      if (l && !lsu_arvalid[d]) begin
         lsu_arvalid[d] = 1'b1;
         lsu_araddr[d]  = $urandom;
         lsu_arsize[d]  = 3'($urandom_range(0, 2));
      end
      if (!l) lsu_arvalid[d] = 1'b0;
   endtask

   // One complete read; rsp_dly >= TMO means the memory never answers
   task automatic serve(input int wr_cyc, input int ar_dly, input bit stray, input int rsp_dly,
                        input int rdy_dly, input logic [31:0] data, input logic [1:0] resp);
      bit          w_lsu;
      bit          hit;
      int          n_resp;
      logic [31:0] e_addr, e_data;
      logic [2:0]  e_size;
      logic [3:0]  e_id;
      logic [1:0]  e_resp;

      lsu_wr_pending[d] = 1'b1;
      for (int i = 0; i < wr_cyc; i++) begin
         #1;
         chk1("wr_block_ifu_arready", ifu_arready[d], 1'b0);
         chk1("wr_block_lsu_arready", lsu_arready[d], 1'b0);
         chk1("wr_block_mem_arvalid", mem_arvalid[d], 1'b0);
         @(negedge clk);
      end
      lsu_wr_pending[d] = 1'b0;
      #1;
      if (ifu_arvalid[d] && lsu_arvalid[d]) w_lsu = prio[d] || !last_lsu;
      else                                  w_lsu = lsu_arvalid[d];
      last_lsu = w_lsu;
      e_addr = w_lsu ? lsu_araddr[d] : ifu_araddr[d];
      e_size = w_lsu ? lsu_arsize[d] : 3'b010;
      e_id   = w_lsu ? 4'd1 : 4'd0;
      chk1("grant_ifu_arready", ifu_arready[d], !w_lsu);
      chk1("grant_lsu_arready", lsu_arready[d], w_lsu);
      chk1("grant_mem_arvalid", mem_arvalid[d], 1'b0);
      chk1("idle_mem_rready", mem_rready[d], 1'b1);
      @(negedge clk);
      if (w_lsu) lsu_arvalid[d] = 1'b0;
      else       ifu_arvalid[d] = 1'b0;

      for (int i = 0; i <= ar_dly; i++) begin
         mem_arready[d] = (i == ar_dly);
         #1;
         chk1("addr_mem_arvalid", mem_arvalid[d], 1'b1);
         chk32("addr_mem_araddr", mem_araddr[d], e_addr);
         chk32("addr_mem_arsize", 32'(mem_arsize[d]), 32'(e_size));
         chk32("addr_mem_arid", 32'(mem_arid[d]), 32'(e_id));
         chk1("addr_no_ifu_arready", ifu_arready[d], 1'b0);
         chk1("addr_no_lsu_arready", lsu_arready[d], 1'b0);
         @(negedge clk);
      end
      mem_arready[d] = 1'b0;

      hit    = (rsp_dly < int'(TMO));
      n_resp = hit ? rsp_dly + 1 : int'(TMO);
      e_data = hit ? data : 32'd0;
      e_resp = hit ? resp : 2'b10;
      for (int j = 0; j < n_resp; j++) begin
         mem_rvalid[d] = 1'b0;
         mem_rdata[d]  = $urandom;
         mem_rresp[d]  = 2'($urandom);
         mem_rid[d]    = e_id ^ 4'd1;
         if (hit && j == rsp_dly) begin
            mem_rvalid[d] = 1'b1;
            mem_rid[d]    = e_id;
            mem_rdata[d]  = data;
            mem_rresp[d]  = resp;
         end else if (stray && j == 0) begin
            mem_rvalid[d] = 1'b1;
            mem_rid[d]    = e_id ^ 4'($urandom_range(1, 15));
         end
         #1;
         chk1("resp_mem_rready", mem_rready[d], 1'b1);
         chk1("resp_ifu_rvalid", ifu_rvalid[d], 1'b0);
         chk1("resp_lsu_rvalid", lsu_rvalid[d], 1'b0);
         @(negedge clk);
      end
      mem_rvalid[d] = 1'b0;

      for (int k = 0; k <= rdy_dly; k++) begin
         if (w_lsu) lsu_rready[d] = (k == rdy_dly);
         else       ifu_rready[d] = (k == rdy_dly);
         #1;
         chk1("ret_ifu_rvalid", ifu_rvalid[d], !w_lsu);
         chk1("ret_lsu_rvalid", lsu_rvalid[d], w_lsu);
         chk32("ret_rdata", w_lsu ? lsu_rdata[d] : ifu_rdata[d], e_data);
         chk32("ret_rresp", 32'(w_lsu ? lsu_rresp[d] : ifu_rresp[d]), 32'(e_resp));
         chk1("ret_mem_rready", mem_rready[d], 1'b0);
         @(negedge clk);
      end
      ifu_rready[d] = 1'b0;
      lsu_rready[d] = 1'b0;
      #1;
      chk1("done_rvalid", w_lsu ? lsu_rvalid[d] : ifu_rvalid[d], 1'b0);
      chk1("done_mem_rready", mem_rready[d], 1'b1);

      if (!hit && !ifu_arvalid[d] && !lsu_arvalid[d]) begin
         mem_rvalid[d] = 1'b1;
         mem_rid[d]    = e_id;
         mem_rdata[d]  = 32'hA5A5_0001;
         mem_rresp[d]  = 2'b00;
         @(negedge clk);
         mem_rvalid[d] = 1'b0;
         #1;
         chk1("late_ifu_rvalid", ifu_rvalid[d], 1'b0);
         chk1("late_lsu_rvalid", lsu_rvalid[d], 1'b0);
         chk32("late_rdata_hold", w_lsu ? lsu_rdata[d] : ifu_rdata[d], e_data);
      end
   endtask

   task automatic run_dut(input int idx);
      vec_t tbl[8];
      bit   ri, rl;

      tbl[0] = '{ifu: 1'b0, lsu: 1'b0, wr: 1'b0, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
      tbl[1] = '{ifu: 1'b1, lsu: 1'b0, wr: 1'b0, exp_ifu_rdy: 1'b1, exp_lsu_rdy: 1'b0};
      tbl[2] = '{ifu: 1'b0, lsu: 1'b1, wr: 1'b0, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b1};
      tbl[3] = '{ifu: 1'b1, lsu: 1'b1, wr: 1'b0, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b1};
      tbl[4] = '{ifu: 1'b0, lsu: 1'b0, wr: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
      tbl[5] = '{ifu: 1'b1, lsu: 1'b0, wr: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
      tbl[6] = '{ifu: 1'b0, lsu: 1'b1, wr: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};
      tbl[7] = '{ifu: 1'b1, lsu: 1'b1, wr: 1'b1, exp_ifu_rdy: 1'b0, exp_lsu_rdy: 1'b0};

      d = idx;
      do_reset();

      // Idle-state grant decisions, withdrawn before each clock edge
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ifu_arvalid[d] = tbl[i].ifu;
         lsu_arvalid[d] = tbl[i].lsu;
         lsu_wr_pending[d] = tbl[i].wr;
         #1;
         chk1("tbl_ifu_arready", ifu_arready[d], tbl[i].exp_ifu_rdy);
         chk1("tbl_lsu_arready", lsu_arready[d], tbl[i].exp_lsu_rdy);
         chk1("tbl_mem_arvalid", mem_arvalid[d], 1'b0);
         #1;
         ifu_arvalid[d] = 1'b0;
         lsu_arvalid[d] = 1'b0;
         lsu_wr_pending[d] = 1'b0;
      end
      @(negedge clk);

      // Minimum-latency IFU fetch
      ifu_araddr[d]  = 32'h8000_0000;
      ifu_arvalid[d] = 1'b1;
      serve(0, 0, 1'b0, 0, 0, 32'hDEAD_BEEF, 2'b00);

      // Two rounds of simultaneous requests
      for (int r = 0; r < 2; r++) begin
         req(1'b1, 1'b1);
         serve(0, 0, 1'b0, 0, 0, $urandom, 2'b00);
         serve(0, 0, 1'b0, 1, 0, $urandom, 2'b01);
      end

      // Write pending holds off both masters
      req(1'b1, 1'b1);
      serve(3, 0, 1'b0, 0, 1, $urandom, 2'b00);
      serve(0, 0, 1'b0, 0, 0, $urandom, 2'b00);

      // Slow AR acceptance
      req(1'b1, 1'b0);
      serve(0, 5, 1'b0, 2, 0, $urandom, 2'b00);

      // Stray beat before the real one
      req(1'b1, 1'b0);
      serve(0, 0, 1'b1, 3, 0, 32'h1234_5678, 2'b00);

      // Silent memory: timeout, then a late beat in idle
      req(1'b0, 1'b1);
      serve(0, 1, 1'b1, int'(TMO), 1, $urandom, 2'b00);

      for (int n = 0; n < 60; n++) begin
         ri = ifu_arvalid[d] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         rl = lsu_arvalid[d] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         if (!ri && !rl) ri = 1'b1;
         req(ri, rl);
         serve(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), $urandom, 2'($urandom));
      end
      req(1'b0, 1'b0);
      @(negedge clk);

      // Reset while waiting for a response
      ifu_araddr[d]  = 32'h0000_0400;
      ifu_arvalid[d] = 1'b1;
      @(negedge clk);
      ifu_arvalid[d] = 1'b0;
      mem_arready[d] = 1'b1;
      @(negedge clk);
      mem_arready[d] = 1'b0;
      lsu_arvalid[d] = 1'b1;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      lsu_arvalid[d] = 1'b0;
      rst_n = 1'b1;
      last_lsu = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("post_rst_ifu_rvalid", ifu_rvalid[d], 1'b0);
      chk1("post_rst_mem_arvalid", mem_arvalid[d], 1'b0);
      req(1'b1, 1'b0);
      serve(0, 0, 1'b0, 0, 0, 32'hCAFE_F00D, 2'b00);
   endtask

   initial begin
      vectors = 0;
      fails   = 0;
      d       = 0;
      prio[0] = 1'b1;
      prio[1] = 1'b0;
      last_lsu = 1'b0;
      rst_n   = 1'b0;
      idle_inputs();
      run_dut(0);
      run_dut(1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
